// File: rtl/execute_stage.sv
// ============================================================================
// execute_stage : Y86-64 execute stage (ALU, condition codes, E/M pipe register)
// Optional: EXECUTE_CMOV_EN makes rrmovq conditional on e_Cnd (cmovXX).
// Revision: 1.0
// ============================================================================
`default_nettype none

module execute_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);
  localparam logic [2:0]       CC_RESET   = 3'b100;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_fun;
  logic [WIDTH-1:0] alu_out;
  logic             alu_of;
  logic             set_cc;
  logic             cnd;
  logic             zf;
  logic             sf;
  logic             of;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_OPQ, I_RRMOVQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = -STACK_STEP;
      I_RET, I_POPQ:              alu_a = STACK_STEP;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_OPQ, I_RMMOVQ, I_MRMOVQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
      default:                                                  alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ) ? E_ifun[1:0] : ALU_ADD;

  // Overflow: operands of the effective same sign produce a result of the other sign.
  always_comb begin
    alu_out = '0;
    alu_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_out = alu_b + alu_a;
        alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = alu_b - alu_a;
        alu_of  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: alu_out = alu_b & alu_a;
      ALU_XOR: alu_out = alu_b ^ alu_a;
      default: alu_out = '0;
    endcase
  end

  assign e_valE = alu_out;

  // E_stat deliberately does not gate CC writes; only downstream status does.
  assign set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cnd = 1'b0;
    case (E_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~(sf ^ of);
      4'h6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign e_Cnd = cnd;

`ifdef EXECUTE_CMOV_EN
  assign e_dstE = ((E_icode == I_RRMOVQ) && !cnd) ? REG_NONE : E_dstE;
`else
  assign e_dstE = E_dstE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      cc <= {(alu_out == '0), alu_out[WIDTH-1], alu_of};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else if (M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else if (!M_stall) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= cnd;
      M_valE  <= alu_out;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// tb_execute_stage : directed bench for execute_stage with a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  E_stat = 3'd1;
  logic [3:0]  E_icode = 4'h1;
  logic [3:0]  E_ifun = 4'h0;
  logic [63:0] E_valC = '0;
  logic [63:0] E_valA = '0;
  logic [63:0] E_valB = '0;
  logic [3:0]  E_dstE = 4'hF;
  logic [3:0]  E_dstM = 4'hF;
  logic [2:0]  m_stat = 3'd1;
  logic [2:0]  W_stat = 3'd1;
  logic        M_stall = 1'b0;
  logic        M_bubble = 1'b0;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  execute_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  logic [2:0]  m_cc;
  logic [2:0]  mM_stat;
  logic [3:0]  mM_icode;
  logic        mM_Cnd;
  logic [63:0] mM_valE;
  logic [63:0] mM_valA;
  logic [3:0]  mM_dstE;
  logic [3:0]  mM_dstM;

  function automatic logic [63:0] f_valE(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    case (ic)
      4'h6: case (fn[1:0])
              2'd0: return b + a;
              2'd1: return b - a;
              2'd2: return b & a;
              default: return b ^ a;
            endcase
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic f_cnd(input logic [2:0] c, input logic [3:0] fn);
    logic lt;
    lt = (c[1] != c[0]);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return lt || c[2];
      4'h2: return lt;
      4'h3: return c[2];
      4'h4: return !c[2];
      4'h5: return !lt;
      4'h6: return !lt && !c[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_dstE(input logic [3:0] ic, input logic cnd, input logic [3:0] d);
`ifdef EXECUTE_CMOV_EN
    if (ic == 4'h2 && !cnd) return 4'hF;
`endif
    return d;
  endfunction

  function automatic logic [2:0] f_cc(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic signed [65:0] wide;
    logic ovf;
    r = f_valE(4'h6, fn, a, b, 64'd0);
    wide = '0;
    ovf = 1'b0;
    if (fn[1:0] == 2'd0) begin
      wide = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
      ovf = (wide > SMAX) || (wide < SMIN);
    end else if (fn[1:0] == 2'd1) begin
      wide = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
      ovf = (wide > SMAX) || (wide < SMIN);
    end
    return {(r == 64'd0), r[63], ovf};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cc <= 3'b100;
      mM_stat <= 3'd1; mM_icode <= 4'h1; mM_Cnd <= 1'b0;
      mM_valE <= '0; mM_valA <= '0; mM_dstE <= 4'hF; mM_dstM <= 4'hF;
    end else begin
      if (E_icode == 4'h6 && m_stat == 3'd1 && W_stat == 3'd1)
        m_cc <= f_cc(E_ifun, E_valA, E_valB);
      if (M_bubble) begin
        mM_stat <= 3'd1; mM_icode <= 4'h1; mM_Cnd <= 1'b0;
        mM_valE <= '0; mM_valA <= '0; mM_dstE <= 4'hF; mM_dstM <= 4'hF;
      end else if (!M_stall) begin
        mM_stat  <= E_stat;
        mM_icode <= E_icode;
        mM_Cnd   <= f_cnd(m_cc, E_ifun);
        mM_valE  <= f_valE(E_icode, E_ifun, E_valA, E_valB, E_valC);
        mM_valA  <= E_valA;
        mM_dstE  <= f_dstE(E_icode, f_cnd(m_cc, E_ifun), E_dstE);
        mM_dstM  <= E_dstM;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("e_valE", e_valE, f_valE(E_icode, E_ifun, E_valA, E_valB, E_valC));
      chk("e_Cnd", 64'(e_Cnd), 64'(f_cnd(m_cc, E_ifun)));
      chk("e_dstE", 64'(e_dstE), 64'(f_dstE(E_icode, f_cnd(m_cc, E_ifun), E_dstE)));
      chk("cc", 64'(cc), 64'(m_cc));
      chk("M_stat", 64'(M_stat), 64'(mM_stat));
      chk("M_icode", 64'(M_icode), 64'(mM_icode));
      chk("M_Cnd", 64'(M_Cnd), 64'(mM_Cnd));
      chk("M_valE", M_valE, mM_valE);
      chk("M_valA", M_valA, mM_valA);
      chk("M_dstE", 64'(M_dstE), 64'(mM_dstE));
      chk("M_dstM", 64'(M_dstM), 64'(mM_dstM));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                     input logic [3:0] dm);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm;
  endtask

  logic [3:0] exp_cmov_dst;

  initial begin
    #1 rst_n = 1'b0;
    #1 run = 1'b1;
    tick();
    tick();
    chk("reset cc", 64'(cc), 64'h4);
    chk("reset M_icode", 64'(M_icode), 64'h1);
    chk("reset M_dstE", 64'(M_dstE), 64'hF);
    chk("reset M_stat", 64'(M_stat), 64'h1);
    rst_n = 1'b1;

    // signed overflow on add
    drv(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h1, 4'hF);
    #1 chk("add e_valE", e_valE, 64'h8000_0000_0000_0000);
    tick();
    chk("add cc", 64'(cc), 64'h3);
    chk("add M_valE", M_valE, 64'h8000_0000_0000_0000);

    // sub to zero, then cmovne
    drv(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);
    #1 chk("sub e_valE", e_valE, 64'd0);
    tick();
    chk("sub cc", 64'(cc), 64'h4);
`ifdef EXECUTE_CMOV_EN
    exp_cmov_dst = 4'hF;
`else
    exp_cmov_dst = 4'h3;
`endif
    drv(4'h2, 4'h4, 64'd77, 64'd0, 64'd0, 4'h3, 4'hF);
    #1 chk("cmovne e_dstE", 64'(e_dstE), 64'(exp_cmov_dst));
    chk("cmovne e_Cnd", 64'(e_Cnd), 64'd0);
    tick();
    chk("cmovne M_dstE", 64'(M_dstE), 64'(exp_cmov_dst));

    // xor with downstream ADR: no CC write
    m_stat = 3'd3;
    drv(4'h6, 4'h3, 64'hF0, 64'hFF, 64'd0, 4'h2, 4'hF);
    #1 chk("xor e_valE", e_valE, 64'h0F);
    tick();
    chk("xor cc held", 64'(cc), 64'h4);
    chk("xor M_valE", M_valE, 64'h0F);
    m_stat = 3'd1;

    // pushq, then call with bubble and stall together
    drv(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF);
    #1 chk("pushq e_valE", e_valE, 64'hF8);
    tick();
    drv(4'h8, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 4'hF);
    M_bubble = 1'b1; M_stall = 1'b1;
    tick();
    chk("bubble M_icode", 64'(M_icode), 64'h1);
    chk("bubble M_dstE", 64'(M_dstE), 64'hF);
    chk("bubble M_valE", M_valE, 64'd0);
    M_bubble = 1'b0; M_stall = 1'b0;

    // stall for three cycles while CC keeps updating
    drv(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h5, 4'hF);
    tick();
    chk("pre-stall M_valE", M_valE, 64'd3);
    M_stall = 1'b1;
    drv(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h6, 4'hF);
    tick();
    chk("stall1 M_valE", M_valE, 64'd3);
    chk("stall1 cc", 64'(cc), 64'h4);
    drv(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h7, 4'hF);
    tick();
    chk("stall2 M_valE", M_valE, 64'd3);
    chk("stall2 cc", 64'(cc), 64'h3);
    drv(4'h3, 4'h0, 64'd0, 64'd0, 64'd9, 4'h8, 4'hF);
    tick();
    chk("stall3 M_valE", M_valE, 64'd3);
    chk("stall3 M_icode", 64'(M_icode), 64'h6);
    chk("stall3 cc", 64'(cc), 64'h3);
    M_stall = 1'b0;

    // asynchronous reset mid-cycle
    drv(4'h3, 4'h0, 64'd0, 64'd0, 64'h42, 4'h2, 4'hF);
    tick();
    chk("irmovq M_valE", M_valE, 64'h42);
    #2 rst_n = 1'b0;
    #1 chk("async M_valE", M_valE, 64'd0);
    chk("async cc", 64'(cc), 64'h4);
    chk("async M_icode", 64'(M_icode), 64'h1);
    tick();
    rst_n = 1'b1;

    // condition evaluation sweep across CC states
    E_stat = 3'd4;
    drv(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);   // INS in E still sets CC
    tick();
    E_stat = 3'd1;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: drv(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);
        1: drv(4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h1, 4'hF);
        2: drv(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h1, 4'hF);
        default: drv(4'h6, 4'h1, 64'd1, 64'd3, 64'd0, 4'h1, 4'hF);
      endcase
      tick();
      for (int f = 0; f < 16; f++) begin
        drv(4'h7, 4'(f), 64'd0, 64'd0, 64'h1000, 4'hF, 4'hF);
        tick();
        drv(4'h2, 4'(f), 64'(f), 64'd0, 64'd0, 4'h4, 4'hF);
        tick();
      end
    end
    chk("sweep end cc", 64'(cc), 64'h0);

    // W_stat HLT blocks the CC write
    W_stat = 3'd2;
    drv(4'h6, 4'h1, 64'd7, 64'd7, 64'd0, 4'h1, 4'hF);
    tick();
    chk("hlt cc held", 64'(cc), 64'h0);
    W_stat = 3'd1;
    tick();

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
